// File: rtl/fifo_ctrl_pkg.sv
// Shared defaults for the FIFO controller and its storage.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 4;
  localparam int DEFAULT_ADDR_WIDTH = 3;
  localparam int DEFAULT_DEPTH      = 1 << DEFAULT_ADDR_WIDTH;

endpackage

// File: rtl/fifo_ctrl_sync_ram.sv
// Storage array: synchronous write, registered read address, combinational output.
module sync_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data
);

  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] rdAddr_q;

  // No reset here: contents and the captured address survive a controller reset.
  always_ff @(posedge clock) begin
    if (write_enable) begin
      mem[write_addr] <= write_data;
    end
    if (read_enable) begin
      rdAddr_q <= read_addr;
    end
  end

  assign read_data = mem[rdAddr_q];

endmodule

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy flags and error pulses around sync_ram.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, empty_q, rdValid_q, overflow_q, underflow_q;
  logic                  wrAccept, rdAccept;

  // Acceptance is gated by reset so the RAM never sees a write in a reset cycle.
  assign wrAccept = wr_en & ~full_q & ~reset;
  assign rdAccept = rd_en & ~empty_q & ~reset;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (wrAccept) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (rdAccept) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    case ({wrAccept, rdAccept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Flags are derived from next-state count so they stay coherent with count every cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      rdValid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      full_q      <= (count_d == FULL_COUNT);
      empty_q     <= (count_d == '0);
      rdValid_q   <= rdAccept;
      overflow_q  <= wr_en & full_q;
      underflow_q <= rd_en & empty_q;
    end
  end

  sync_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) ram (
    .clock       (clock),
    .write_enable(wrAccept),
    .write_addr  (wrPtr_q),
    .write_data  (wr_data),
    .read_enable (rdAccept),
    .read_addr   (rdPtr_q),
    .read_data   (rd_data)
  );

  assign rd_valid  = rdValid_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl with hand-computed expectations.
module tb_fifo_ctrl;
  import fifo_pkg::*;

  localparam int DW = 4;
  localparam int AW = 3;

  logic          clock   = 1'b0;
  logic          reset   = 1'b1;
  logic          wr_en   = 1'b0;
  logic          rd_en   = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, empty, overflow, underflow;
  logic [AW:0]   count;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] model[$];
  logic [DW-1:0] expWord;
  logic [DW-1:0] wd;

  always #5 clock = ~clock;

  fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .underflow(underflow)
  );

  // Drive one cycle of inputs, then settle 1ns past the edge for sampling.
  task automatic applyStimulus(input logic rst, input logic w, input logic [DW-1:0] d,
                               input logic r);
    reset   = rst;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkIdleFlags(input string tag);
    checkOutput({tag, " count"}, 32'(count), 0);
    checkOutput({tag, " empty"}, 32'(empty), 1);
    checkOutput({tag, " full"}, 32'(full), 0);
    checkOutput({tag, " rd_valid"}, 32'(rd_valid), 0);
    checkOutput({tag, " overflow"}, 32'(overflow), 0);
    checkOutput({tag, " underflow"}, 32'(underflow), 0);
  endtask

  initial begin
    // Reset with both requests active: reset must win.
    applyStimulus(1'b1, 1'b1, 4'h7, 1'b1);
    applyStimulus(1'b1, 1'b1, 4'h7, 1'b1);
    checkIdleFlags("reset");

    // Fill with 3..A.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, DW'(3 + i), 1'b0);
      checkOutput($sformatf("fill count %0d", i), 32'(count), 32'(i + 1));
      checkOutput($sformatf("fill empty %0d", i), 32'(empty), 0);
      checkOutput($sformatf("fill full %0d", i), 32'(full), (i == 7) ? 1 : 0);
    end
    checkOutput("full count", 32'(count), 32'(DEFAULT_DEPTH));

    // Write while full is rejected.
    applyStimulus(1'b0, 1'b1, 4'hF, 1'b0);
    checkOutput("ovf pulse", 32'(overflow), 1);
    checkOutput("ovf count", 32'(count), 8);
    checkOutput("ovf full", 32'(full), 1);

    // Full with both requested: read wins, write rejected.
    applyStimulus(1'b0, 1'b1, 4'hF, 1'b1);
    checkOutput("both-full overflow", 32'(overflow), 1);
    checkOutput("both-full count", 32'(count), 7);
    checkOutput("both-full full", 32'(full), 0);
    checkOutput("both-full rd_valid", 32'(rd_valid), 1);
    checkOutput("both-full rd_data", 32'(rd_data), 32'h3);

    // Remaining seven reads, back to back.
    for (int i = 1; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput($sformatf("drain rd_valid %0d", i), 32'(rd_valid), 1);
      checkOutput($sformatf("drain rd_data %0d", i), 32'(rd_data), 32'(3 + i));
      checkOutput($sformatf("drain count %0d", i), 32'(count), 32'(7 - i));
      if (i == 1) checkOutput("ovf cleared", 32'(overflow), 0);
    end
    checkOutput("drained empty", 32'(empty), 1);

    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("idle rd_valid", 32'(rd_valid), 0);

    // Read while empty.
    applyStimulus(1'b0, 1'b0, '0, 1'b1);
    checkOutput("udf pulse", 32'(underflow), 1);
    checkOutput("udf rd_valid", 32'(rd_valid), 0);
    checkOutput("udf count", 32'(count), 0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("udf cleared", 32'(underflow), 0);

    // Empty with both requested: write accepted, read rejected.
    applyStimulus(1'b0, 1'b1, 4'h5, 1'b1);
    model.push_back(4'h5);
    checkOutput("both-empty underflow", 32'(underflow), 1);
    checkOutput("both-empty rd_valid", 32'(rd_valid), 0);
    checkOutput("both-empty count", 32'(count), 1);
    checkOutput("both-empty empty", 32'(empty), 0);

    for (int i = 0; i < 3; i++) begin
      wd = DW'(6 + i);
      model.push_back(wd);
      applyStimulus(1'b0, 1'b1, wd, 1'b0);
    end
    checkOutput("hold count", 32'(count), 4);

    // Steady state at count 4; both pointers wrap.
    for (int i = 0; i < 12; i++) begin
      wd      = DW'(9 + i);
      expWord = model.pop_front();
      model.push_back(wd);
      applyStimulus(1'b0, 1'b1, wd, 1'b1);
      checkOutput($sformatf("stream rd_valid %0d", i), 32'(rd_valid), 1);
      checkOutput($sformatf("stream rd_data %0d", i), 32'(rd_data), 32'(expWord));
      checkOutput($sformatf("stream count %0d", i), 32'(count), 4);
    end
    checkOutput("stream full", 32'(full), 0);
    checkOutput("stream empty", 32'(empty), 0);

    applyStimulus(1'b0, 1'b1, 4'hC, 1'b0);
    checkOutput("pre-reset count", 32'(count), 5);

    // Reset with count 5 and both requests active.
    applyStimulus(1'b1, 1'b1, 4'hD, 1'b1);
    checkIdleFlags("mid reset");

    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkIdleFlags("post reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 4, giving the width of a stored word.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 3, giving the address width; depth is 2**ADDR_WIDTH (8 entries).
REQ-003 clock  input  1  single clock; all state changes on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  write request.
REQ-006 wr_data  input  DATA_WIDTH  word to store.
REQ-007 rd_en  input  1  read request.
REQ-008 rd_data  output  DATA_WIDTH  word read; meaningful only while rd_valid=1.
REQ-009 rd_valid  output  1  rd_data holds the word of a read accepted in the previous cycle.
REQ-010 full  output  1  count equals depth.
REQ-011 empty  output  1  count equals 0.
REQ-012 count  output  ADDR_WIDTH+1  number of stored words, 0..depth.
REQ-013 overflow  output  1  one-cycle pulse: write requested but rejected.
REQ-014 underflow  output  1  one-cycle pulse: read requested but rejected.

Function
REQ-015 The block SHALL accept a write iff wr_en=1, full=0 and reset=0, storing wr_data at wr_ptr on that posedge.
REQ-016 The block SHALL accept a read iff rd_en=1, empty=0 and reset=0, registering rd_ptr as the RAM read address on that posedge.
REQ-017 Read latency SHALL be one cycle: rd_valid=1 and rd_data equal to the word at the registered address in the cycle after acceptance; otherwise rd_valid=0.
REQ-018 Pointers SHALL increment by 1 per accepted operation and wrap from depth-1 to 0.
REQ-019 count SHALL change by +1 on write-only, -1 on read-only, and 0 when both are accepted or neither is.
REQ-020 When full and both requested: read accepted, write rejected, overflow=1, count becomes depth-1.
REQ-021 When empty and both requested: write accepted, read rejected, underflow=1, rd_valid=0 next cycle, count becomes 1.
REQ-022 full, empty and count SHALL be registered outputs consistent with one another in every cycle.
REQ-023 overflow and underflow SHALL be registered and assert for exactly one cycle per rejected request.
REQ-024 A slot freed by a read SHALL NOT be rewritten before the end of the cycle in which rd_valid presents it.
REQ-025 rd_data outside rd_valid cycles SHALL be don't-care; RAM contents SHALL be unaffected by rejected operations.

Reset
REQ-026 While reset=1, the block SHALL on each posedge set wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_valid=0, overflow=0 and underflow=0.
REQ-027 Reset SHALL take priority over simultaneous wr_en/rd_en; no RAM write SHALL occur in a reset cycle.
REQ-028 RAM contents SHALL NOT be cleared by reset.

Structure
REQ-029 Package fifo_pkg SHALL hold DATA_WIDTH, ADDR_WIDTH and DEPTH defaults.
REQ-030 Storage SHALL be one sub-module, sync_ram: synchronous write on posedge when write_enable, registered read address, asynchronous output from the registered address.

Verification
REQ-031 Reset, then write 3,4,...,A (8 writes) -> count=8, full=1 after the 8th edge, empty=0.
REQ-032 With the FIFO full, write F -> overflow=1 for one cycle, count stays 8, later reads return no F.
REQ-033 Read 8 times back-to-back -> rd_valid=1 on 8 consecutive cycles with rd_data 3,4,...,A; empty=1 after the last read.
REQ-034 Read while empty -> underflow=1 for one cycle, rd_valid=0, count stays 0.
REQ-035 Hold count=4 and apply wr_en=rd_en=1 for 12 cycles (pointers wrap) -> count stays 4 and read data in write order.
REQ-036 Assert reset with count=5 and wr_en=rd_en=1 -> next cycle count=0, empty=1, rd_valid=0, flags 0.
